// File: rtl/jtcps1_sndrom_arb.sv
// Sound ROM arbiter: shares one SDRAM read slot between the Z80 program ROM and the ADPCM ROM.
// Each requester has a one-entry cache (last address, data byte, valid bit). A miss issues a
// level request to the SDRAM slot; the slot answers with an ack pulse and later a data pulse.
//
// Ports:
//   clk, rst          48 MHz clock, synchronous active-high reset
//   z80_addr/cs       Z80 ROM byte address and level read request
//   z80_data/ok       cached Z80 byte and hit indication (combinational)
//   pcm_addr/cs       ADPCM ROM byte address and level read request
//   pcm_data/ok       cached ADPCM byte and hit indication (combinational)
//   sdram_addr/req    registered byte address and level request to the SDRAM slot
//   sdram_ack         slot accepted the request (one-cycle pulse)
//   sdram_dst         sdram_data valid (one-cycle pulse)
//   sdram_data        read data from the slot
module jtcps1_sndrom_arb #(
  parameter logic [19:0] PCM_BASE  = 20'h10000,
  parameter logic        SWAP_BYTE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [15:0] z80_addr,
  input  logic        z80_cs,
  output logic [7:0]  z80_data,
  output logic        z80_ok,

  input  logic [17:0] pcm_addr,
  input  logic        pcm_cs,
  output logic [7:0]  pcm_data,
  output logic        pcm_ok,

  output logic [19:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [7:0]  sdram_data
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q, state_d;

  logic        z80_valid_q;
  logic [15:0] z80_last_q;
  logic [7:0]  z80_data_q;
  logic        pcm_valid_q;
  logic [17:0] pcm_last_q;
  logic [7:0]  pcm_data_q;

  logic        owner_pcm_q;     // owner of the transfer in flight: 1 = PCM, 0 = Z80
  logic        last_pcm_q;      // requester granted most recently: 1 = PCM, 0 = Z80
  logic [17:0] addr_q;          // requester-side address latched at grant
  logic [19:0] sdram_addr_q;

  logic        z80_pend, pcm_pend;
  logic        grant, grant_pcm;
  logic        fill;
  logic [19:0] pcm_sdram_addr;
  logic [19:0] grant_addr;

  // Hits are gated by rst so both ok outputs are low for the whole reset assertion,
  // including the first cycle before the valid bits have been cleared.
  assign z80_ok   = ~rst & z80_cs & z80_valid_q & (z80_addr == z80_last_q);
  assign pcm_ok   = ~rst & pcm_cs & pcm_valid_q & (pcm_addr == pcm_last_q);
  assign z80_data = z80_data_q;
  assign pcm_data = pcm_data_q;

  assign z80_pend = z80_cs & ~z80_ok;
  assign pcm_pend = pcm_cs & ~pcm_ok;

  assign sdram_req  = (state_q == StReq);
  assign sdram_addr = sdram_addr_q;

  // 20-bit sum wraps naturally modulo 2^20.
  assign pcm_sdram_addr = PCM_BASE + {2'd0, pcm_addr};
  assign grant_addr     = (grant_pcm ? pcm_sdram_addr : {4'd0, z80_addr}) ^ {19'd0, SWAP_BYTE};

  assign fill = (state_q == StWait) & sdram_dst;

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_pcm = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (z80_pend || pcm_pend) begin
          grant     = 1'b1;
          // On contention the requester not granted last wins.
          grant_pcm = pcm_pend & (~z80_pend | ~last_pcm_q);
          state_d   = StReq;
        end
      end
      StReq: begin
        if (sdram_ack) state_d = StWait;
      end
      StWait: begin
        if (sdram_dst) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      z80_valid_q  <= 1'b0;
      z80_last_q   <= '0;
      z80_data_q   <= '0;
      pcm_valid_q  <= 1'b0;
      pcm_last_q   <= '0;
      pcm_data_q   <= '0;
      owner_pcm_q  <= 1'b0;
      last_pcm_q   <= 1'b0;
      addr_q       <= '0;
      sdram_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_pcm_q  <= grant_pcm;
        last_pcm_q   <= grant_pcm;
        addr_q       <= grant_pcm ? pcm_addr : {2'd0, z80_addr};
        sdram_addr_q <= grant_addr;
      end
      // The fill uses the address latched at grant, so a requester that moved on while the
      // transfer was in flight simply misses again afterwards.
      if (fill) begin
        if (owner_pcm_q) begin
          pcm_data_q  <= sdram_data;
          pcm_last_q  <= addr_q;
          pcm_valid_q <= 1'b1;
        end else begin
          z80_data_q  <= sdram_data;
          z80_last_q  <= addr_q[15:0];
          z80_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtcps1_sndrom_arb.sv
// Directed bench for jtcps1_sndrom_arb. Three instances share all inputs and run in lockstep:
// default parameters, PCM_BASE=20'hF0000 (wrap case) and SWAP_BYTE=1.
module tb_jtcps1_sndrom_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] z80_addr;
  logic        z80_cs;
  logic [17:0] pcm_addr;
  logic        pcm_cs;
  logic        sdram_ack;
  logic        sdram_dst;
  logic [7:0]  sdram_data;

  logic [7:0]  z80_data_w [3];
  logic        z80_ok_w   [3];
  logic [7:0]  pcm_data_w [3];
  logic        pcm_ok_w   [3];
  logic [19:0] sdram_addr_w [3];
  logic        sdram_req_w  [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  jtcps1_sndrom_arb u_dut0 (
    .clk(clk), .rst(rst),
    .z80_addr(z80_addr), .z80_cs(z80_cs), .z80_data(z80_data_w[0]), .z80_ok(z80_ok_w[0]),
    .pcm_addr(pcm_addr), .pcm_cs(pcm_cs), .pcm_data(pcm_data_w[0]), .pcm_ok(pcm_ok_w[0]),
    .sdram_addr(sdram_addr_w[0]), .sdram_req(sdram_req_w[0]), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_data(sdram_data)
  );

  jtcps1_sndrom_arb #(.PCM_BASE(20'hF0000)) u_dut1 (
    .clk(clk), .rst(rst),
    .z80_addr(z80_addr), .z80_cs(z80_cs), .z80_data(z80_data_w[1]), .z80_ok(z80_ok_w[1]),
    .pcm_addr(pcm_addr), .pcm_cs(pcm_cs), .pcm_data(pcm_data_w[1]), .pcm_ok(pcm_ok_w[1]),
    .sdram_addr(sdram_addr_w[1]), .sdram_req(sdram_req_w[1]), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_data(sdram_data)
  );

  jtcps1_sndrom_arb #(.SWAP_BYTE(1'b1)) u_dut2 (
    .clk(clk), .rst(rst),
    .z80_addr(z80_addr), .z80_cs(z80_cs), .z80_data(z80_data_w[2]), .z80_ok(z80_ok_w[2]),
    .pcm_addr(pcm_addr), .pcm_cs(pcm_cs), .pcm_data(pcm_data_w[2]), .pcm_ok(pcm_ok_w[2]),
    .sdram_addr(sdram_addr_w[2]), .sdram_req(sdram_req_w[2]), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_data(sdram_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, capture the three instances' addresses, then ack and dst.
  task automatic xfer(input logic [7:0] d, output logic [19:0] a0, output logic [19:0] a1,
                      output logic [19:0] a2);
    int n = 0;
    while (!sdram_req_w[0] && n < 20) begin
      step();
      n++;
    end
    check("req_seen", {31'd0, sdram_req_w[0]}, 32'd1);
    a0 = sdram_addr_w[0];
    a1 = sdram_addr_w[1];
    a2 = sdram_addr_w[2];
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    check("req_drop", {31'd0, sdram_req_w[0]}, 32'd0);
    step();
    sdram_dst  = 1'b1;
    sdram_data = d;
    step();
    sdram_dst  = 1'b0;
    sdram_data = 8'h00;
  endtask

  initial begin
    logic [19:0] a0, a1, a2;
    int n;

    rst        = 1'b1;
    z80_addr   = '0;
    z80_cs     = 1'b0;
    pcm_addr   = '0;
    pcm_cs     = 1'b0;
    sdram_ack  = 1'b0;
    sdram_dst  = 1'b0;
    sdram_data = 8'h00;
    step();
    step();

    // Reset state
    check("rst_req", {31'd0, sdram_req_w[0]}, 32'd0);
    check("rst_addr", {12'd0, sdram_addr_w[0]}, 32'd0);
    check("rst_z80_data", {24'd0, z80_data_w[0]}, 32'd0);
    check("rst_pcm_data", {24'd0, pcm_data_w[0]}, 32'd0);
    z80_cs = 1'b1;
    pcm_cs = 1'b1;
    #1;
    check("rst_z80_ok", {31'd0, z80_ok_w[0]}, 32'd0);
    check("rst_pcm_ok", {31'd0, pcm_ok_w[0]}, 32'd0);
    z80_cs = 1'b0;
    pcm_cs = 1'b0;
    rst    = 1'b0;
    step();

    // Z80 miss: ack 2 cycles after req, dst 3 cycles after ack
    z80_cs   = 1'b1;
    z80_addr = 16'h1234;
    step();
    check("z80_req", {31'd0, sdram_req_w[0]}, 32'd1);
    check("z80_addr", {12'd0, sdram_addr_w[0]}, 32'h01234);
    check("z80_miss_ok", {31'd0, z80_ok_w[0]}, 32'd0);
    step();
    check("z80_req_held", {31'd0, sdram_req_w[0]}, 32'd1);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    check("z80_req_after_ack", {31'd0, sdram_req_w[0]}, 32'd0);
    step();
    step();
    sdram_dst  = 1'b1;
    sdram_data = 8'hA5;
    step();
    sdram_dst  = 1'b0;
    sdram_data = 8'h00;
    check("z80_ok", {31'd0, z80_ok_w[0]}, 32'd1);
    check("z80_data", {24'd0, z80_data_w[0]}, 32'hA5);
    check("z80_pcm_ok", {31'd0, pcm_ok_w[0]}, 32'd0);
    n = 0;
    repeat (5) begin
      step();
      if (sdram_req_w[0]) n++;
    end
    check("z80_hit_no_req", n, 32'd0);
    z80_addr = 16'h1235;
    #1;
    check("z80_ok_drop_same_cycle", {31'd0, z80_ok_w[0]}, 32'd0);
    z80_cs   = 1'b0;
    z80_addr = 16'h1234;
    step();

    // PCM offset and wrap
    pcm_cs   = 1'b1;
    pcm_addr = 18'h3FFFF;
    xfer(8'h3C, a0, a1, a2);
    check("pcm_addr_base", {12'd0, a0}, 32'h4FFFF);
    check("pcm_addr_wrap", {12'd0, a1}, 32'h2FFFF);
    check("pcm_ok", {31'd0, pcm_ok_w[0]}, 32'd1);
    check("pcm_data", {24'd0, pcm_data_w[0]}, 32'h3C);
    check("pcm_z80_untouched", {24'd0, z80_data_w[0]}, 32'hA5);
    pcm_cs = 1'b0;

    // Simultaneous misses right after reset: PCM first
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_z80_data", {24'd0, z80_data_w[0]}, 32'd0);
    z80_cs   = 1'b1;
    z80_addr = 16'h0100;
    pcm_cs   = 1'b1;
    pcm_addr = 18'h00200;
    xfer(8'h11, a0, a1, a2);
    check("pair1_first_pcm", {12'd0, a0}, 32'h10200);
    check("pair1_pcm_ok", {31'd0, pcm_ok_w[0]}, 32'd1);
    check("pair1_z80_wait", {31'd0, z80_ok_w[0]}, 32'd0);
    xfer(8'h22, a0, a1, a2);
    check("pair1_second_z80", {12'd0, a0}, 32'h00100);
    check("pair1_z80_ok", {31'd0, z80_ok_w[0]}, 32'd1);
    check("pair1_pcm_keep", {24'd0, pcm_data_w[0]}, 32'h11);
    // PCM alone, so it becomes last served
    pcm_addr = 18'h00201;
    xfer(8'h33, a0, a1, a2);
    check("pcm_single", {12'd0, a0}, 32'h10201);
    // Second pair: Z80 first
    z80_addr = 16'h0101;
    pcm_addr = 18'h00202;
    xfer(8'h44, a0, a1, a2);
    check("pair2_first_z80", {12'd0, a0}, 32'h00101);
    xfer(8'h55, a0, a1, a2);
    check("pair2_second_pcm", {12'd0, a0}, 32'h10202);
    check("pair2_z80_data", {24'd0, z80_data_w[0]}, 32'h44);
    check("pair2_pcm_data", {24'd0, pcm_data_w[0]}, 32'h55);
    z80_cs = 1'b0;
    pcm_cs = 1'b0;
    step();

    // Address change in flight
    z80_cs   = 1'b1;
    z80_addr = 16'h0010;
    n = 0;
    while (!sdram_req_w[0] && n < 20) begin
      step();
      n++;
    end
    check("chg_req", {31'd0, sdram_req_w[0]}, 32'd1);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    z80_addr  = 16'h0011;
    step();
    sdram_dst  = 1'b1;
    sdram_data = 8'h5A;
    step();
    sdram_dst  = 1'b0;
    sdram_data = 8'h00;
    check("chg_ok_low", {31'd0, z80_ok_w[0]}, 32'd0);
    check("chg_data", {24'd0, z80_data_w[0]}, 32'h5A);
    z80_addr = 16'h0010;
    #1;
    check("chg_filled_old_addr", {31'd0, z80_ok_w[0]}, 32'd1);
    z80_addr = 16'h0011;
    xfer(8'h77, a0, a1, a2);
    check("chg_new_req", {12'd0, a0}, 32'h00011);
    check("chg_new_ok", {31'd0, z80_ok_w[0]}, 32'd1);
    check("chg_new_data", {24'd0, z80_data_w[0]}, 32'h77);

    // SWAP_BYTE
    z80_addr = 16'h0002;
    xfer(8'h66, a0, a1, a2);
    check("swap_off", {12'd0, a0}, 32'h00002);
    check("swap_on", {12'd0, a2}, 32'h00003);
    check("swap_z80_ok", {31'd0, z80_ok_w[2]}, 32'd1);

    // Reset mid-WAIT
    pcm_cs   = 1'b1;
    pcm_addr = 18'h00300;
    n = 0;
    while (!sdram_req_w[0] && n < 20) begin
      step();
      n++;
    end
    check("rstw_req", {31'd0, sdram_req_w[0]}, 32'd1);
    check("rstw_addr", {12'd0, sdram_addr_w[0]}, 32'h10300);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    check("rstw_z80_hit", {31'd0, z80_ok_w[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_ok_gated", {31'd0, z80_ok_w[0]}, 32'd0);
    step();
    rst = 1'b0;
    check("rstw_req_low", {31'd0, sdram_req_w[0]}, 32'd0);
    step();
    sdram_dst  = 1'b1;
    sdram_data = 8'h99;
    step();
    sdram_dst  = 1'b0;
    sdram_data = 8'h00;
    check("rstw_z80_ok", {31'd0, z80_ok_w[0]}, 32'd0);
    check("rstw_pcm_ok", {31'd0, pcm_ok_w[0]}, 32'd0);
    check("rstw_pcm_data", {24'd0, pcm_data_w[0]}, 32'd0);
    check("rstw_z80_data", {24'd0, z80_data_w[0]}, 32'd0);
    z80_cs = 1'b0;
    pcm_cs = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
